float_add_pipe: RTL and testbench

FLOAT_ADD_PIPE -- requirements
Module: float_add_pipe

---
 rtl/float_pkg.sv | 32 +++
 rtl/float_norm_round.sv | 52 +++++
 rtl/float_add_pipe.sv | 149 ++++++++++++++
 tb/tb_float_add_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared constants, operand classes and bit-pattern helpers for the pipelined float adder.
package float_pkg;
  localparam int EXP_W_DEF = 5;
  localparam int MAN_W_DEF = 10;
  localparam int GRS_W     = 3;

  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} fcls_e;

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int emax_of(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // Patterns are built wide and truncated to the word width by the user.
  function automatic logic [63:0] inf_word(input int exp_w, input int man_w);
    return 64'(emax_of(exp_w)) << man_w;
  endfunction

  function automatic logic [63:0] qnan_word(input int exp_w, input int man_w);
    return inf_word(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

  // Exponent 0 is treated as zero: subnormals are flushed on input.
  function automatic fcls_e classify(input logic exp_zero, input logic exp_ones, input logic man_nz);
    if (exp_zero) return CLS_ZERO;
    if (!exp_ones) return CLS_NORM;
    return man_nz ? CLS_NAN : CLS_INF;
  endfunction
endpackage

// File: rtl/float_norm_round.sv
// Combinational leading-zero count, normalising shift, round-to-nearest-even and pack.
module float_norm_round
  import float_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                     sign,
  input  logic [EXP_W-1:0]         exp_big,
  input  logic [MAN_W+GRS_W+1:0]   mag,
  output logic [EXP_W+MAN_W:0]     res,
  output logic                     ovf
);
  localparam int AW   = MAN_W + GRS_W + 2;
  localparam int EMAX = emax_of(EXP_W);

  int lz;
  int exp_n;
  logic found;
  logic [AW-1:0] norm;
  logic round_up;
  logic [MAN_W+1:0] rnd;
  logic [MAN_W-1:0] man_out;

  always_comb begin
    lz = 0;
    found = 1'b0;
    for (int i = AW - 1; i >= 0; i--) begin
      if (!found) begin
        if (mag[i]) found = 1'b1;
        else lz = lz + 1;
      end
    end
    // Leading one lands in the top (carry) position; exponent corrects by 1 - lz.
    norm = mag << lz;
    round_up = norm[GRS_W] && ((|norm[GRS_W-1:0]) || norm[GRS_W+1]);
    rnd = {1'b0, norm[AW-1:GRS_W+1]} + {{(MAN_W+1){1'b0}}, round_up};
    exp_n = int'(exp_big) + 1 - lz + int'(rnd[MAN_W+1]);
    man_out = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];

    res = '0;
    ovf = 1'b0;
    if (!found || exp_n < 1) begin
      res = '0;
    end else if (exp_n >= EMAX) begin
      res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf = 1'b1;
    end else begin
      res = {sign, exp_n[EXP_W-1:0], man_out};
    end
  end
endmodule

// File: rtl/float_add_pipe.sv
// Three-stage floating-point adder/subtractor: S1 unpack/swap/align, S2 add, S3 normalise/round.
module float_add_pipe
  import float_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] float_a,
  input  logic [EXP_W+MAN_W:0] float_b,
  input  logic                 op_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] sum,
  output logic                 overflow
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1 + GRS_W;
  localparam int AW = SW + 1;
  localparam int SH_MAX = MAN_W + GRS_W;
  localparam logic [W-1:0] QNAN = W'(qnan_word(EXP_W, MAN_W));
  localparam logic [W-1:0] INF  = W'(inf_word(EXP_W, MAN_W));

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  logic sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  fcls_e ca, cb;

  assign sa = float_a[W-1];
  assign ea = float_a[W-2:MAN_W];
  assign ma = float_a[MAN_W-1:0];
  assign sb = float_b[W-1] ^ op_sub;
  assign eb = float_b[W-2:MAN_W];
  assign mb = float_b[MAN_W-1:0];
  assign ca = classify(ea == '0, &ea, |ma);
  assign cb = classify(eb == '0, &eb, |mb);

  // Specials and zero operands bypass the arithmetic path entirely.
  logic spec_c;
  logic [W-1:0] spec_val_c;
  always_comb begin
    spec_c = 1'b1;
    spec_val_c = '0;
    if (ca == CLS_NAN || cb == CLS_NAN || (ca == CLS_INF && cb == CLS_INF && sa != sb))
      spec_val_c = QNAN;
    else if (ca == CLS_INF)
      spec_val_c = {sa, INF[W-2:0]};
    else if (cb == CLS_INF)
      spec_val_c = {sb, INF[W-2:0]};
    else if (ca == CLS_ZERO && cb == CLS_ZERO)
      spec_val_c = '0;
    else if (ca == CLS_ZERO)
      spec_val_c = {sb, eb, mb};
    else if (cb == CLS_ZERO)
      spec_val_c = float_a;
    else
      spec_c = 1'b0;
  end

  logic a_big, s_big, s_small;
  logic [EXP_W-1:0] e_big, e_small, diff;
  logic [SW-1:0] sig_big, sig_small, aligned;
  logic [2*SW-1:0] wide;
  int unsigned sh;
  always_comb begin
    a_big     = {ea, ma} >= {eb, mb};
    s_big     = a_big ? sa : sb;
    s_small   = a_big ? sb : sa;
    e_big     = a_big ? ea : eb;
    e_small   = a_big ? eb : ea;
    sig_big   = a_big ? {1'b1, ma, {GRS_W{1'b0}}} : {1'b1, mb, {GRS_W{1'b0}}};
    sig_small = a_big ? {1'b1, mb, {GRS_W{1'b0}}} : {1'b1, ma, {GRS_W{1'b0}}};
    diff      = e_big - e_small;
    sh        = (32'(diff) > SH_MAX) ? SH_MAX : 32'(diff);
    // Lower half of the wide shift collects everything that falls off into the sticky bit.
    wide      = {sig_small, {SW{1'b0}}} >> sh;
    aligned   = wide[2*SW-1:SW] | {{(SW-1){1'b0}}, |wide[SW-1:0]};
  end

  logic v1, spec1, sign1, sub1;
  logic [W-1:0] spec_val1;
  logic [EXP_W-1:0] exp1;
  logic [SW-1:0] big1, small1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; spec1 <= 1'b0; sign1 <= 1'b0; sub1 <= 1'b0;
      spec_val1 <= '0; exp1 <= '0; big1 <= '0; small1 <= '0;
    end else if (advance) begin
      v1        <= in_valid;
      spec1     <= spec_c;
      spec_val1 <= spec_val_c;
      sign1     <= s_big;
      sub1      <= s_big != s_small;
      exp1      <= e_big;
      big1      <= sig_big;
      small1    <= aligned;
    end
  end

  logic [AW-1:0] mag_c;
  assign mag_c = sub1 ? ({1'b0, big1} - {1'b0, small1}) : ({1'b0, big1} + {1'b0, small1});

  logic v2, spec2, sign2;
  logic [W-1:0] spec_val2;
  logic [EXP_W-1:0] exp2;
  logic [AW-1:0] mag2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0; spec2 <= 1'b0; sign2 <= 1'b0;
      spec_val2 <= '0; exp2 <= '0; mag2 <= '0;
    end else if (advance) begin
      v2        <= v1;
      spec2     <= spec1;
      spec_val2 <= spec_val1;
      sign2     <= sign1;
      exp2      <= exp1;
      mag2      <= mag_c;
    end
  end

  logic [W-1:0] res_c;
  logic ovf_c;
  float_norm_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_norm (
    .sign    (sign2),
    .exp_big (exp2),
    .mag     (mag2),
    .res     (res_c),
    .ovf     (ovf_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      overflow  <= 1'b0;
    end else if (advance) begin
      out_valid <= v2;
      sum       <= spec2 ? spec_val2 : res_c;
      overflow  <= !spec2 && ovf_c;
    end
  end
endmodule

// File: tb/tb_float_add_pipe.sv
// Self-checking bench: directed fp16 cases plus a random stream against a real-arithmetic model.
module tb_float_add_pipe;
  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready;
  logic [15:0] float_a, float_b;
  logic op_sub;
  logic out_valid, out_ready;
  logic [15:0] sum;
  logic overflow;

  always #5 clk = ~clk;

  float_add_pipe #(.EXP_W(5), .MAN_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .float_a   (float_a),
    .float_b   (float_b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .overflow  (overflow)
  );

  typedef struct { logic [15:0] s; logic o; int c; } exp_t;
  exp_t sb[$];
  int n_asrt = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_acc = 0;
  bit lat_chk = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_asrt++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real v;
    if (h[14:10] == 5'd0) return 0.0;
    v = real'(1024 + int'(h[9:0])) * pow2(int'(h[14:10]) - 25);
    return h[15] ? -v : v;
  endfunction

  // Round an exactly representable real to fp16: RNE, flush tiny results, saturate to inf.
  function automatic void r2h(input real x, output logic [15:0] h, output logic ov);
    real a, sc, fr;
    int e, m, be;
    logic s;
    h = 16'h0000;
    ov = 1'b0;
    if (x == 0.0) return;
    s = (x < 0.0);
    a = s ? -x : x;
    e = 0;
    while (a >= pow2(e + 1)) e++;
    while (a < pow2(e)) e--;
    sc = a / pow2(e - 10);
    m = $rtoi(sc);
    fr = sc - real'(m);
    if (fr > 0.5 || (fr == 0.5 && (m % 2) == 1)) m++;
    if (m == 2048) begin m = 1024; e++; end
    be = e + 15;
    if (be < 1) h = 16'h0000;
    else if (be >= 31) begin h = {s, 5'h1F, 10'h000}; ov = 1'b1; end
    else h = {s, 5'(be), 10'(m - 1024)};
  endfunction

  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic op,
                                output logic [15:0] r, output logic ov);
    logic [15:0] bn;
    logic a_inf, b_inf, a_nan, b_nan;
    bn = {b[15] ^ op, b[14:0]};
    a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    b_nan = (bn[14:10] == 5'h1F) && (bn[9:0] != 10'd0);
    a_inf = (a[14:10] == 5'h1F) && !a_nan;
    b_inf = (bn[14:10] == 5'h1F) && !b_nan;
    r = 16'h0000;
    ov = 1'b0;
    if (a_nan || b_nan) r = 16'h7E00;
    else if (a_inf && b_inf) r = (a[15] == bn[15]) ? a : 16'h7E00;
    else if (a_inf) r = a;
    else if (b_inf) r = bn;
    else r2h(h2r(a) + h2r(bn), r, ov);
  endfunction

  // One clock cycle: drive, score any handshake on either side, advance.
  task automatic tick(input logic iv, input logic [15:0] a, input logic [15:0] b, input logic op,
                      input logic ordy, input logic [15:0] xs, input logic xo);
    exp_t e;
    in_valid = iv; float_a = a; float_b = b; op_sub = op; out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sum", {16'd0, sum}, {16'd0, e.s});
        check("overflow", {31'd0, overflow}, {31'd0, e.o});
        if (lat_chk) check("latency", cyc - e.c, 32'd3);
      end
    end
    if (in_valid && in_ready) begin
      e.s = xs; e.o = xo; e.c = cyc;
      sb.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0);
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while (sb.size() != 0 && k < limit) begin
      tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0);
      k++;
    end
    check("drain_left", sb.size(), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, b, xs;
    logic op, xo;
    int target, guard;

    rst = 1'b1; in_valid = 1'b0; float_a = 16'h0; float_b = 16'h0; op_sub = 1'b0; out_ready = 1'b1;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Back-to-back directed stream with fixed latency.
    lat_chk = 1'b1;
    tick(1, 16'h3C00, 16'h4000, 0, 1, 16'h4200, 0);
    tick(1, 16'h3C00, 16'h3C00, 1, 1, 16'h0000, 0);
    tick(1, 16'h3C00, 16'h1000, 0, 1, 16'h3C00, 0);
    tick(1, 16'h3C01, 16'h1000, 0, 1, 16'h3C02, 0);
    tick(1, 16'h7BFF, 16'h7BFF, 0, 1, 16'h7C00, 1);
    tick(1, 16'h7C00, 16'hFC00, 0, 1, 16'h7E00, 0);
    tick(1, 16'h0400, 16'h0401, 1, 1, 16'h0000, 0);
    tick(1, 16'h8000, 16'h8000, 0, 1, 16'h0000, 0);
    tick(1, 16'h7C01, 16'h3C00, 0, 1, 16'h7E00, 0);
    tick(1, 16'h3C00, 16'h7C00, 1, 1, 16'hFC00, 0);
    tick(1, 16'h0000, 16'h3C00, 1, 1, 16'hBC00, 0);
    tick(1, 16'hC000, 16'h0000, 0, 1, 16'hC000, 0);
    tick(1, 16'hFBFF, 16'h7BFF, 1, 1, 16'hFC00, 1);
    drain(10);
    idle(4);
    lat_chk = 1'b0;

    // Backpressure: three in flight, output stalled for five cycles.
    tick(1, 16'h3C00, 16'h4000, 0, 1, 16'h4200, 0);
    tick(1, 16'h4000, 16'h4000, 0, 1, 16'h4400, 0);
    tick(1, 16'h3C00, 16'h3C00, 1, 1, 16'h0000, 0);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; float_a = 16'h4400; float_b = 16'h3C00; op_sub = 1'b0; out_ready = 1'b0;
      #1;
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_sum_hold", {16'd0, sum}, 32'h4200);
      @(posedge clk); #1;
      cyc++;
    end
    tick(1, 16'h4400, 16'h3C00, 0, 1, 16'h4500, 0);
    drain(10);
    idle(4);

    // Reset with two pairs in flight.
    tick(1, 16'h3C00, 16'h4000, 0, 1, 16'h4200, 0);
    tick(1, 16'h4400, 16'h4400, 0, 1, 16'h4800, 0);
    tick(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_sum", {16'd0, sum}, 32'd0);
    check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    cyc++;
    check("in_ready_after_mid_rst", {31'd0, in_ready}, 32'd1);
    tick(1, 16'h4000, 16'h4000, 0, 1, 16'h4400, 0);
    drain(10);
    idle(6);

    // Random regression with random backpressure.
    target = n_acc + 10000;
    guard = 0;
    while (n_acc < target && guard < 60000) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 1) == 1) b[14:10] = a[14:10] + 5'($urandom_range(0, 4)) - 5'd2;
      op = 1'($urandom_range(0, 1));
      model(a, b, op, xs, xo);
      tick($urandom_range(0, 9) < 8, a, b, op, $urandom_range(0, 9) < 7, xs, xo);
      guard++;
    end
    check("rand_accepted", n_acc, target);
    drain(50);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
